// File: rtl/joycon_pkg.sv
// Shared definitions for the NES pad poller and the CPU-facing joycon register block.
package joycon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    GAP   = 3'd2,
    HIGH  = 3'd3,
    LOW   = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Bit positions inside the 8-bit snapshot, in the order the pad shifts them out.
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic [7:0] BTN_NONE = 8'hFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/joycon_sync2.sv
// Two-flop synchronizer for the asynchronous pad data line; idles high like the pad pull-up.
module joycon_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joycon_pad_poller.sv
// Host-side poller for a CD4021-style NES pad: periodic latch, 7 shift clocks, 8-bit snapshot.
module joycon_pad_poller
  import joycon_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned POLL_CYCLES  = 833333
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned TMAX = max_u(LATCH_CYCLES, HALF_CYCLES);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned IW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYCLES - 1);
  localparam logic [IW-1:0] POLL_LAST  = IW'(POLL_CYCLES - 1);

  state_e        state, state_n;
  logic [TW-1:0] timer;
  logic [IW-1:0] interval;
  logic [2:0]    bit_idx;
  logic [7:0]    capture;
  logic          pd_s;
  logic          poll_tick;
  logic          phase_last;

  joycon_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_data),
    .q   (pd_s)
  );

  // Free-running poll interval; independent of enable and of the state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      interval <= '0;
    end else if (poll_tick) begin
      interval <= '0;
    end else begin
      interval <= interval + IW'(1);
    end
  end

  assign poll_tick  = (interval == POLL_LAST);
  assign phase_last = (state == LATCH) ? (timer == LATCH_LAST) : (timer == HALF_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (poll_tick && enable) state_n = LATCH;
      LATCH:   if (phase_last) state_n = GAP;
      GAP:     if (phase_last) state_n = HIGH;
      HIGH:    if (phase_last) state_n = LOW;
      LOW:     if (phase_last) state_n = (bit_idx == 3'd7) ? DONE : HIGH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

  // Pad strobes are decoded from the next state so the registered pins line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= (state_n != state || state == IDLE) ? '0 : timer + TW'(1);
      pad_latch <= (state_n == LATCH);
      pad_clk   <= (state_n == HIGH);
    end
  end

  // NOTE: the capture register is reset too, so an interrupted poll never leaks stale bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capture <= BTN_NONE;
      bit_idx <= '0;
      buttons <= BTN_NONE;
    end else begin
      if (state == GAP && phase_last) begin
        capture[0] <= pd_s;
        bit_idx    <= 3'd1;
      end
      if (state == LOW && phase_last) begin
        capture[bit_idx] <= pd_s;
        if (bit_idx == 3'd7) begin
          // Snapshot lands on the DONE cycle, together with the valid pulse.
          buttons <= {pd_s, capture[6:0]};
        end else begin
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_joycon_pad_poller.sv
// Directed bench for joycon_pad_poller against a behavioural CD4021 pad model.
module tb_joycon_pad_poller;

  localparam int unsigned L = 4;
  localparam int unsigned H = 4;
  localparam int unsigned P = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, valid, busy;
  logic [7:0] buttons;

  logic [7:0] pad_value = 8'hFF;
  logic [7:0] sr = 8'hFF;
  logic       no_pad = 1'b0;
  logic       mdl_pclk_q = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor process)
  int cyc = 0, latch_cyc_total = 0, latch_rises = 0, latch_rise_cyc = 0;
  int clk_rises = 0, valid_count = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
  int btn_glitch = 0;
  logic [7:0] last_valid_btn = 8'hFF, btn_q = 8'hFF;
  logic latch_q = 1'b0, pclk_q = 1'b0, rst_q = 1'b0;

  joycon_pad_poller #(
    .LATCH_CYCLES (L),
    .HALF_CYCLES  (H),
    .POLL_CYCLES  (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign pad_data = no_pad ? 1'b1 : sr[0];

  // CD4021: parallel load while latch high, shift toward bit 0 on clock rise, fill with 1.
  always @(negedge clk) begin
    if (pad_latch) sr <= pad_value;
    else if (pad_clk && !mdl_pclk_q) sr <= {1'b1, sr[7:1]};
    mdl_pclk_q <= pad_clk;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pad_latch) latch_cyc_total = latch_cyc_total + 1;
    if (pad_latch && !latch_q) begin
      latch_rises    = latch_rises + 1;
      latch_rise_cyc = cyc;
    end
    if (pad_clk && !pclk_q) clk_rises = clk_rises + 1;
    if (valid) begin
      valid_count    = valid_count + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      last_valid_btn = buttons;
    end
    if (rst && rst_q && buttons != btn_q && !valid) btn_glitch = btn_glitch + 1;
    latch_q = pad_latch;
    pclk_q  = pad_clk;
    rst_q   = rst;
    btn_q   = buttons;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int base = valid_count;
    int n = 0;
    while (valid_count == base && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_seen"}, 32'(valid_count != base), 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int k, input int budget);
    int base = clk_rises;
    int n = 0;
    while ((clk_rises - base) < k && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_seen"}, 32'((clk_rises - base) >= k), 32'd1);
  endtask

  initial begin
    int lc0, cr0, vc0, lr0, n;

    // Reset state
    step(3);
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_pclk", 32'(pad_clk), 32'd0);
    check("rst_buttons", 32'(buttons), 32'hFF);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // First poll: 8'hFE
    pad_value = 8'hFE;
    enable = 1'b1;
    rst = 1'b1;
    lc0 = latch_cyc_total;
    cr0 = clk_rises;
    wait_valid("fe", 2 * P);
    check("fe_buttons", 32'(last_valid_btn), 32'hFE);
    check("fe_latch_cycles", 32'(latch_cyc_total - lc0), 32'(L));
    check("fe_clk_rises", 32'(clk_rises - cr0), 32'd7);
    check("fe_poll_len", 32'(last_valid_cyc - latch_rise_cyc + 1), 32'(L + 15 * H + 1));

    // Two successive polls: 5A then A5
    pad_value = 8'h5A;
    wait_valid("5a", 2 * P);
    check("5a_buttons", 32'(last_valid_btn), 32'h5A);
    pad_value = 8'hA5;
    step(100);
    check("5a_hold", 32'(buttons), 32'h5A);
    wait_valid("a5", 2 * P);
    check("a5_buttons", 32'(last_valid_btn), 32'hA5);
    check("a5_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(P));

    // enable low from reset: no activity
    rst = 1'b0;
    enable = 1'b0;
    step(3);
    rst = 1'b1;
    lc0 = latch_cyc_total;
    cr0 = clk_rises;
    vc0 = valid_count;
    step(1000);
    check("dis_latch", 32'(latch_cyc_total - lc0), 32'd0);
    check("dis_pclk", 32'(clk_rises - cr0), 32'd0);
    check("dis_valid", 32'(valid_count - vc0), 32'd0);
    check("dis_buttons", 32'(buttons), 32'hFF);

    // enable dropped during HIGH of bit 3
    pad_value = 8'h3C;
    enable = 1'b1;
    wait_rises("en3", 3, 2 * P);
    check("en3_in_high", 32'(pad_clk), 32'd1);
    enable = 1'b0;
    wait_valid("en3", 2 * P);
    check("en3_buttons", 32'(last_valid_btn), 32'h3C);
    lr0 = latch_rises;
    vc0 = valid_count;
    step(500);
    check("en3_no_latch", 32'(latch_rises - lr0), 32'd0);
    check("en3_no_valid", 32'(valid_count - vc0), 32'd0);

    // Reset mid-LOW, then a clean poll of 8'h00
    pad_value = 8'h96;
    enable = 1'b1;
    wait_rises("rlow", 4, 2 * P);
    n = 0;
    while (pad_clk && n < 2 * H) begin
      step(1);
      n++;
    end
    step(1);
    check("rlow_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rlow_pclk", 32'(pad_clk), 32'd0);
    check("rlow_latch", 32'(pad_latch), 32'd0);
    check("rlow_busy", 32'(busy), 32'd0);
    check("rlow_valid", 32'(valid), 32'd0);
    check("rlow_buttons", 32'(buttons), 32'hFF);
    step(3);
    pad_value = 8'h00;
    rst = 1'b1;
    wait_valid("zero", 2 * P);
    check("zero_buttons", 32'(last_valid_btn), 32'h00);

    // No pad: line pulled high
    no_pad = 1'b1;
    wait_valid("nopad1", 2 * P);
    check("nopad1_buttons", 32'(last_valid_btn), 32'hFF);
    wait_valid("nopad2", 2 * P);
    check("nopad2_buttons", 32'(last_valid_btn), 32'hFF);
    check("nopad_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(P));

    check("buttons_stable", 32'(btn_glitch), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
